// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: address/count width derivation and pointer compares,
// common to the single- and dual-clock FIFOs.
package fifo_pkg;

  function automatic int addr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int count_width(input int depth);
    return addr_width(depth) + 1;
  endfunction

  // Pointers carry one extra wrap bit above the address bits; aw = address bits.
  function automatic logic ptr_full(input logic [31:0] wp, input logic [31:0] rp, input int aw);
    logic [31:0] diff;
    logic [31:0] mask;
    diff = wp ^ rp;
    mask = (32'd1 << aw) - 32'd1;
    return (((diff >> aw) & 32'd1) == 32'd1) && ((diff & mask) == 32'd0);
  endfunction

  function automatic logic ptr_empty(input logic [31:0] wp, input logic [31:0] rp);
    return wp == rp;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer bundle for sync_fifo; the FIFO takes the slave side.
interface sync_fifo_if #(
  parameter int DATASIZE = 8,
  parameter int DEPTH    = 16
) ();
  import fifo_pkg::*;
  localparam int CNTSIZE = count_width(DEPTH);

  // Handshake: a write is taken on a rising edge with wr_en && !full, a read
  // with rd_en && !empty; requests against full/empty are dropped and latch
  // the sticky overflow/underflow flags until clr_err.
  logic                wr_en;
  logic [DATASIZE-1:0] data_in;
  logic                rd_en;
  logic                clr_err;
  logic [DATASIZE-1:0] data_out;
  logic                full;
  logic                empty;
  logic                almost_full;
  logic                almost_empty;
  logic [CNTSIZE-1:0]  count;
  logic                overflow;
  logic                underflow;

  modport master (
    output wr_en, data_in, rd_en, clr_err,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en, clr_err,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port RAM, one clock, registered read port. Only the read
// register is reset; the array itself is never cleared.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int DEPTH    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [addr_width(DEPTH)-1:0]  wr_addr,
  input  logic [DATASIZE-1:0]           wr_data,
  input  logic                          rd_en,
  input  logic [addr_width(DEPTH)-1:0]  rd_addr,
  output logic [DATASIZE-1:0]           rd_data
);
  logic [DATASIZE-1:0] mem_q [DEPTH];
  logic [DATASIZE-1:0] rd_data_q;
  logic [DATASIZE-1:0] rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky error flags
// and an optional first-word-fall-through read mode.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int DEPTH    = 16,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input logic        clk,
  input logic        rst,
  sync_fifo_if.slave bus
);
  localparam int ADDRSIZE = addr_width(DEPTH);
  localparam int PTRW     = ADDRSIZE + 1;
  localparam int CNTSIZE  = count_width(DEPTH);
  localparam logic [CNTSIZE-1:0] ONE_C   = CNTSIZE'(1);
  localparam logic [CNTSIZE-1:0] DEPTH_C = CNTSIZE'(DEPTH);
  localparam logic [CNTSIZE-1:0] AF_C    = CNTSIZE'(AF_LEVEL);
  localparam logic [CNTSIZE-1:0] AE_C    = CNTSIZE'(AE_LEVEL);

  logic [PTRW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTSIZE-1:0]  count_q, count_d;
  logic                full_q, full_d, empty_q, empty_d;
  logic                af_q, af_d, ae_q, ae_d;
  logic                ovf_q, ovf_d, unf_q, unf_d;
  logic                valid_q, valid_d;
  logic                wr_acc, rd_acc, ram_rd_en, mem_has_data;
  logic [DATASIZE-1:0] ram_rd_data;

  always_comb begin
    wr_acc       = bus.wr_en && !full_q && !rst;
    rd_acc       = bus.rd_en && !empty_q && !rst;
    mem_has_data = !ptr_empty(32'(wr_ptr_q), 32'(rd_ptr_q));

    // In FWFT the RAM's read register doubles as the one-word output stage:
    // it refills whenever it is empty or being popped and memory holds data.
    if (FWFT != 0) ram_rd_en = mem_has_data && (!valid_q || rd_acc) && !rst;
    else           ram_rd_en = rd_acc;

    wr_ptr_d = wr_ptr_q + PTRW'(wr_acc);
    rd_ptr_d = rd_ptr_q + PTRW'(ram_rd_en);

    count_d = count_q;
    if (wr_acc && !rd_acc)      count_d = count_q + ONE_C;
    else if (rd_acc && !wr_acc) count_d = count_q - ONE_C;

    valid_d = valid_q;
    if (ram_rd_en)   valid_d = 1'b1;
    else if (rd_acc) valid_d = 1'b0;

    if (FWFT != 0) begin
      full_d  = (count_d == DEPTH_C);
      empty_d = !valid_d;
    end else begin
      full_d  = ptr_full(32'(wr_ptr_d), 32'(rd_ptr_d), ADDRSIZE);
      empty_d = ptr_empty(32'(wr_ptr_d), 32'(rd_ptr_d));
    end

    af_d = (count_d >= AF_C);
    ae_d = (count_d <= AE_C);

    // An error in the same cycle as clr_err keeps the flag set.
    ovf_d = ovf_q;
    if (bus.wr_en && full_q) ovf_d = 1'b1;
    else if (bus.clr_err)    ovf_d = 1'b0;

    unf_d = unf_q;
    if (bus.rd_en && empty_q) unf_d = 1'b1;
    else if (bus.clr_err)     unf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      valid_q  <= valid_d;
    end
  end

  fifo_ram #(
    .DATASIZE(DATASIZE),
    .DEPTH   (DEPTH)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr_q[ADDRSIZE-1:0]),
    .wr_data(bus.data_in),
    .rd_en  (ram_rd_en),
    .rd_addr(rd_ptr_q[ADDRSIZE-1:0]),
    .rd_data(ram_rd_data)
  );

  assign bus.data_out     = ram_rd_data;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO that succeeds the dual-clock memory block for same-domain buffering. Adds occupancy count, programmable almost-full and almost-empty thresholds, sticky overflow and underflow flags, and a selectable first-word-fall-through (FWFT) read mode. It sits between a producer and a consumer in one clock domain and owns its pointers, flags and storage.

## Interface
- DATASIZE, 8: word width in bits.
- DEPTH, 16: number of entries; power of two, ≥ 2.
- FWFT, 0: 0 = standard read (data one cycle after rd_en); 1 = first-word-fall-through.
- AF_LEVEL, DEPTH-2: almost_full asserts when count ≥ AF_LEVEL.
- AE_LEVEL, 2: almost_empty asserts when count ≤ AE_LEVEL.
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- data_in  in  DATASIZE  write data.
- rd_en  in  1  read request (in FWFT: pop/acknowledge the head word).
- clr_err  in  1  clears the sticky overflow and underflow flags.
- data_out  out  DATASIZE  read data.
- full, empty  out  1  occupancy flags.
- almost_full, almost_empty  out  1  threshold flags.
- count  out  ADDRSIZE+1  words held (ADDRSIZE = $clog2(DEPTH)).
- overflow, underflow  out  1  sticky error flags.

## Operation
- Pointers are ADDRSIZE+1 bits; the MSB is the wrap bit. full = (MSBs differ, address bits equal). empty = (pointers equal) in standard mode.
- Write accept: wr_en && !full. Read accept: rd_en && !empty. There is no write-through when full, even if a read is accepted in the same cycle.
- Rejected write (wr_en && full): storage and pointers are unchanged; overflow sets.
- Rejected read (rd_en && empty): data_out holds its value; underflow sets.
- clr_err clears both sticky flags. If clr_err and an error occur in the same cycle, the error wins and the flag stays set.
- count changes by +1 (write only), -1 (read only), or 0 (both accepted, or neither). Count never exceeds DEPTH.
- Standard mode:
  - data_out loads mem[rd_ptr] on an accepted read.
  - data_out otherwise holds its value.
- FWFT mode:
  - A one-word output register is prefetched from memory whenever it is empty and memory holds data.
  - The empty output reflects the output register's valid bit.
  - count includes the prefetched word.
  - rd_en with !empty consumes the word. A refill from memory happens on the same edge if any word remains, so back-to-back reads run at one word per cycle.
- Reset:
  - Pointers, count, overflow, underflow and the FWFT valid bit are cleared.
  - data_out resets to 0; full = 0, empty = 1, almost_full = 0, almost_empty = 1.
  - Memory contents are not reset.
  - Reset asserted mid-stream discards all contents at that edge. Any wr_en or rd_en in the reset cycle is ignored.

## Timing
- All flags and count are registered. They reflect every accepted operation from the edge on which it is accepted.
- Standard mode:
  - A write at edge N: empty = 0 and count updated after N.
  - rd_en accepted at edge N: data_out valid after N (one-cycle latency).
- FWFT mode:
  - A write to an empty FIFO at edge N: head word on data_out and empty = 0 after edge N+1 (two-cycle fall-through latency).
  - The popped word is replaced by the next word after the same edge.
- Wrap-around: pointers roll from 2·DEPTH-1 to 0 with no bubble.
- Full ↔ empty transitions:
  - full deasserts on the edge of the first accepted read.
  - empty deasserts per the mode latency above.

## Structure
- Package fifo_pkg holds:
  - the address-width function (clog2 wrapper);
  - the count-width derivation;
  - the pointer-compare helpers for full/empty, shared with the dual-clock FIFO.
- One sub-module, fifo_ram: simple dual-port RAM with registered read and a single clk. It is parametrised by DATASIZE and DEPTH, with write enable and read enable.
- sync_fifo owns the pointers, count, flags, error logic and the FWFT prefetch register.

## Test plan
- Fill then drain, DATASIZE=8, DEPTH=16, FWFT=0:
  - write 0x00..0x0F → full=1 and count=16 after the 16th write;
  - almost_full=1 from count 14;
  - read 16 → data 0x00..0x0F in order, each one cycle after its rd_en;
  - empty=1 and count=0 at the end.
- Overflow/underflow:
  - a 17th write when full → data unchanged, overflow=1;
  - rd_en when empty → underflow=1, data_out held;
  - clr_err → both flags 0 next cycle.
- Simultaneous read and write:
  - at count=5, wr_en and rd_en held for 40 cycles → count stays 5, pointers wrap twice, data order preserved;
  - at full, both asserted → write rejected, read accepted, count=15.
- FWFT=1:
  - write 0xA5 into an empty FIFO at edge N → data_out=0xA5 and empty=0 after N+1;
  - a burst of 4 writes, then rd_en held high → 4 words on 4 consecutive cycles;
  - empty=1 after the last pop.
- Mid-operation reset at count=9 with wr_en high → count=0, empty=1, flags cleared at that edge, and no write taken.
